// File: rtl/l2_pkg.sv
// rtl/l2_pkg.sv - shared L2 op codes, trace-code enum and queued-op entry type
`timescale 1ns/1ps
package l2_pkg;

  localparam int L2_TAG_BITS   = 12;
  localparam int L2_INDEX_BITS = 14;

  // ASCII operation bytes understood by the L2
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_M = 8'h4D;
  localparam logic [7:0] OP_I = 8'h49;

  // Trace-file command codes; 7 and 10-15 are illegal
  typedef enum logic [3:0] {
    TC_READ        = 4'd0,
    TC_WRITE       = 4'd1,
    TC_IFETCH      = 4'd2,
    TC_SNOOP_INV   = 4'd3,
    TC_SNOOP_READ  = 4'd4,
    TC_SNOOP_WRITE = 4'd5,
    TC_SNOOP_RFO   = 4'd6,
    TC_CLEAR       = 4'd8,
    TC_PRINT       = 4'd9
  } trace_code_e;

  typedef struct packed {
    logic [7:0]               op_code;
    logic                     snoop;
    logic [L2_TAG_BITS-1:0]   tag;
    logic [L2_INDEX_BITS-1:0] index;
  } op_entry_t;

  localparam int OP_ENTRY_BITS = $bits(op_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PULSE = 2'd2
  } disp_state_e;

endpackage

// File: rtl/trace_cmd_dispatcher_sync_fifo.sv
// rtl/trace_cmd_dispatcher_sync_fifo.sv - synchronous FIFO with push/pop/full/empty/count
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Overflowing push or underflowing pop is ignored rather than corrupting state
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: empty/count gate whether the head is meaningful
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/trace_cmd_dispatcher.sv
// rtl/trace_cmd_dispatcher.sv - trace command decode, op FIFO and clear/print sequencer (option: DISPATCH_STATS_EN)
`timescale 1ns/1ps
module trace_cmd_dispatcher
  import l2_pkg::*;
#(
  parameter int addrBits   = 32,
  parameter int tagBits    = L2_TAG_BITS,
  parameter int indexBits  = L2_INDEX_BITS,
  parameter int offsetBits = 6,
  parameter int depth      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_code,
  input  logic [addrBits-1:0]  cmd_addr,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [7:0]           op_code,
  output logic                 op_snoop,
  output logic [tagBits-1:0]   op_tag,
  output logic [indexBits-1:0] op_index,
  output logic                 clear_req,
  output logic                 print_req,
  output logic                 cmd_err
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_reads,
  output logic [31:0]          stat_writes,
  output logic [31:0]          stat_snoops
`endif
);

  disp_state_e r_state;
  logic        r_is_print;
  logic        r_clear_req;
  logic        r_print_req;
  logic        r_cmd_err;

  op_entry_t   w_new_entry;
  op_entry_t   w_head;
  logic        w_queue;
  logic        w_seq;
  logic        w_illegal;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [$clog2(depth):0] w_unused_count;
  logic        w_unused_addr;

  // Byte offset inside the 64B line carries no meaning for the L2
  assign w_unused_addr = ^cmd_addr[offsetBits-1:0];

  // Commands are accepted only while idle and with room to queue
  assign cmd_ready = !reset && (r_state == ST_IDLE) && !w_full;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_push    = w_accept && w_queue;
  assign w_pop     = op_valid && op_ready;

  // Map trace code to L2 op byte and snoop flag; split address into tag/index
  always_comb begin
    w_new_entry       = '0;
    w_queue           = 1'b0;
    w_seq             = 1'b0;
    w_illegal         = 1'b0;
    w_new_entry.tag   = cmd_addr[addrBits-1 -: tagBits];
    w_new_entry.index = cmd_addr[offsetBits +: indexBits];
    case (cmd_code)
      TC_READ, TC_IFETCH: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_R;
      end
      TC_WRITE: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_W;
      end
      TC_SNOOP_INV: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_I;
        w_new_entry.snoop   = 1'b1;
      end
      TC_SNOOP_READ: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_R;
        w_new_entry.snoop   = 1'b1;
      end
      TC_SNOOP_WRITE: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_W;
        w_new_entry.snoop   = 1'b1;
      end
      TC_SNOOP_RFO: begin
        w_queue             = 1'b1;
        w_new_entry.op_code = OP_M;
        w_new_entry.snoop   = 1'b1;
      end
      TC_CLEAR, TC_PRINT: w_seq = 1'b1;
      default:            w_illegal = 1'b1;
    endcase
  end

  sync_fifo #(
    .WIDTH (OP_ENTRY_BITS),
    .DEPTH (depth)
  ) u_op_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_new_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_unused_count)
  );

  assign op_valid  = !w_empty;
  assign op_code   = w_head.op_code;
  assign op_snoop  = w_head.snoop;
  assign op_tag    = w_head.tag;
  assign op_index  = w_head.index;
  assign clear_req = r_clear_req;
  assign print_req = r_print_req;
  assign cmd_err   = r_cmd_err;

  // Sequencer: clear/print wait until every earlier op has left the FIFO, then pulse once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_print  <= 1'b0;
      r_clear_req <= 1'b0;
      r_print_req <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_cmd_err   <= w_accept && w_illegal;
      r_clear_req <= 1'b0;
      r_print_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_seq) begin
            r_is_print <= (cmd_code == TC_PRINT);
            r_state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_clear_req <= !r_is_print;
            r_print_req <= r_is_print;
            r_state     <= ST_PULSE;
          end
        end
        ST_PULSE: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_stat_reads;
  logic [31:0] r_stat_writes;
  logic [31:0] r_stat_snoops;
  logic        w_inc_read;
  logic        w_inc_write;
  logic        w_inc_snoop;

  assign w_inc_read  = w_push && !w_new_entry.snoop && (w_new_entry.op_code == OP_R);
  assign w_inc_write = w_push && !w_new_entry.snoop && (w_new_entry.op_code == OP_W);
  assign w_inc_snoop = w_push && w_new_entry.snoop;

  // Saturating op counters, wiped together with the cache on clear
  always_ff @(posedge clk) begin
    if (reset || r_clear_req) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
      r_stat_snoops <= '0;
    end else begin
      if (w_inc_read  && (r_stat_reads  != '1)) r_stat_reads  <= r_stat_reads  + 1'b1;
      if (w_inc_write && (r_stat_writes != '1)) r_stat_writes <= r_stat_writes + 1'b1;
      if (w_inc_snoop && (r_stat_snoops != '1)) r_stat_snoops <= r_stat_snoops + 1'b1;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
  assign stat_snoops = r_stat_snoops;
`endif

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// tb/tb_trace_cmd_dispatcher.sv - scoreboard bench for trace_cmd_dispatcher
`timescale 1ns/1ps
module tb_trace_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_code;
  logic [31:0] cmd_addr;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  op_code;
  logic        op_snoop;
  logic [11:0] op_tag;
  logic [13:0] op_index;
  logic        clear_req;
  logic        print_req;
  logic        cmd_err;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_snoops;
`endif

  always #5 clk = ~clk;

  trace_cmd_dispatcher dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_code  (cmd_code),
    .cmd_addr  (cmd_addr),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_snoop  (op_snoop),
    .op_tag    (op_tag),
    .op_index  (op_index),
    .clear_req (clear_req),
    .print_req (print_req),
    .cmd_err   (cmd_err)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_snoops (stat_snoops)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pops = 0;
  int          n_clear = 0;
  int          n_print = 0;
  int          n_err = 0;
  logic [34:0] sb [$];
  logic        hold_pending = 1'b0;
  logic [34:0] hold_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [34:0] ent(input logic [7:0] c, input logic s,
                                      input logic [11:0] t, input logic [13:0] i);
    return {c, s, t, i};
  endfunction

  // Monitor: pops the scoreboard on each L2 handshake, checks head stability, counts pulses
  always @(negedge clk) begin
    logic [34:0] cur_v;
    logic [34:0] exp_v;
    cur_v = {op_code, op_snoop, op_tag, op_index};
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("hold_stable", cur_v, hold_val);
      if (op_valid && op_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got op 0x%0h required no op", cur_v);
        end else begin
          exp_v = sb.pop_front();
          check("sb_op", cur_v, exp_v);
        end
      end
      hold_pending = op_valid && !op_ready;
      hold_val     = cur_v;
      if (clear_req) n_clear++;
      if (print_req) n_print++;
      if (cmd_err)   n_err++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code, input logic [31:0] addr);
    bit ok;
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_addr  = addr;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
      cyc();
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: code %0d not accepted, required within 30 cycles", code);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt0;
    int   cnt1;
    logic exp_clr [5];
    logic exp_rdy [5];
    logic exp_prt [3];
    logic exp_rdy3 [3];

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_code  = 4'd0;
    cmd_addr  = 32'd0;
    op_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    cyc();
    @(negedge clk);
    check("rst_op_valid", op_valid, 0);
    check("rst_clear_req", clear_req, 0);
    check("rst_print_req", print_req, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_cmd_ready_held", cmd_ready, 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_op_valid", op_valid, 0);
    cyc();

    // 1: single write, 1-cycle latency, field split
    sb.push_back(ent(8'h57, 1'b0, 12'h123, 14'h1159));
    send(4'd1, 32'h1234_5678);
    @(negedge clk);
    check("t1_op_valid", op_valid, 1);
    check("t1_op_code", op_code, 8'h57);
    check("t1_op_snoop", op_snoop, 0);
    check("t1_op_tag", op_tag, 12'h123);
    check("t1_op_index", op_index, 14'h1159);
`ifdef DISPATCH_STATS_EN
    check("t1_stat_writes", stat_writes, 1);
    check("t1_stat_reads", stat_reads, 0);
`endif
    cyc();
    op_ready = 1'b1;
    cyc();
    cyc();
    op_ready = 1'b0;
    check("t1_drained", sb.size(), 0);

    // 2: fill FIFO, fifth command back-pressured until a pop frees a slot
    sb.push_back(ent(8'h52, 1'b0, 12'h000, 14'h0001));
    send(4'd0, 32'h0000_0040);
    sb.push_back(ent(8'h52, 1'b1, 12'hFFF, 14'h0000));
    send(4'd4, 32'hFFF0_0000);
    sb.push_back(ent(8'h57, 1'b1, 12'h001, 14'h0000));
    send(4'd5, 32'h0010_0000);
    sb.push_back(ent(8'h4D, 1'b1, 12'h000, 14'h3FFF));
    send(4'd6, 32'h000F_FFC0);
    @(negedge clk);
    check("t2_full_ready", cmd_ready, 0);
    check("t2_full_op_valid", op_valid, 1);
    cmd_valid = 1'b1;
    cmd_code  = 4'd3;
    cmd_addr  = 32'hABCD_EF80;
    sb.push_back(ent(8'h49, 1'b1, 12'hABC, 14'h37BE));
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("t2_fifth_held", cmd_ready, 0);
    end
    cyc();
    op_ready = 1'b1;
    @(negedge clk);
    check("t2_no_write_through", cmd_ready, 0);
    cyc();
    @(negedge clk);
    check("t2_ready_after_pop", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    repeat (6) cyc();
    op_ready = 1'b0;
    check("t2_drained", sb.size(), 0);

    // 3: clear waits for queued ops, then one-cycle pulse
    sb.push_back(ent(8'h52, 1'b0, 12'h000, 14'h0002));
    send(4'd0, 32'h0000_0080);
    sb.push_back(ent(8'h52, 1'b0, 12'h003, 14'h0004));
    send(4'd0, 32'h0030_0100);
    send(4'd8, 32'h0);
    cnt0 = n_clear;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_no_clear_while_queued", clear_req, 0);
      check("t3_drain_ready", cmd_ready, 0);
      cyc();
    end
    op_ready = 1'b1;
    exp_clr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t3_clear_seq%0d", k), clear_req, exp_clr[k]);
      check($sformatf("t3_ready_seq%0d", k), cmd_ready, exp_rdy[k]);
      cyc();
    end
    op_ready = 1'b0;
    check("t3_clear_once", n_clear - cnt0, 1);
    check("t3_drained", sb.size(), 0);

    // 3b: print with empty FIFO: one DRAIN cycle, then the pulse
    cnt0 = n_print;
    cnt1 = n_clear;
    send(4'd9, 32'h0);
    exp_prt  = '{1'b0, 1'b1, 1'b0};
    exp_rdy3 = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t3b_print_seq%0d", k), print_req, exp_prt[k]);
      check($sformatf("t3b_ready_seq%0d", k), cmd_ready, exp_rdy3[k]);
      cyc();
    end
    check("t3b_print_once", n_print - cnt0, 1);
    check("t3b_no_clear", n_clear - cnt1, 0);

    // 4: illegal codes pulse cmd_err and queue nothing
    cnt0 = n_err;
    send(4'd7, 32'h0000_1000);
    @(negedge clk);
    check("t4_err7", cmd_err, 1);
    check("t4_op_valid7", op_valid, 0);
    cyc();
    @(negedge clk);
    check("t4_err7_low", cmd_err, 0);
    cyc();
    send(4'd12, 32'h0000_2000);
    @(negedge clk);
    check("t4_err12", cmd_err, 1);
    check("t4_op_valid12", op_valid, 0);
    cyc();
    @(negedge clk);
    check("t4_err12_low", cmd_err, 0);
    check("t4_op_valid_end", op_valid, 0);
    cyc();
    check("t4_err_count", n_err - cnt0, 2);

    // 5: one op per cycle across three pointer wraps
    op_ready = 1'b1;
    cnt0 = n_pops;
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1;
      cmd_code  = 4'(i % 3);
      cmd_addr  = (32'(i) << 20) | (32'(i) << 6);
      sb.push_back(ent((i % 3 == 1) ? 8'h57 : 8'h52, 1'b0, 12'(i), 14'(i)));
      @(negedge clk);
      check("t5_ready", cmd_ready, 1);
      if (i > 0) check("t5_op_valid", op_valid, 1);
      cyc();
    end
    cmd_valid = 1'b0;
    cyc();
    cyc();
    op_ready = 1'b0;
    check("t5_pop_count", n_pops - cnt0, 12);
    check("t5_drained", sb.size(), 0);

    // 6: reset while three ops queued and sequencer in DRAIN
    send(4'd0, 32'h0000_0040);
    send(4'd1, 32'h0000_0080);
    send(4'd4, 32'h0000_00C0);
    send(4'd8, 32'h0);
    cnt0 = n_clear;
    @(negedge clk);
    check("t6_drain_ready", cmd_ready, 0);
    check("t6_queued_valid", op_valid, 1);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("t6_reset_ready", cmd_ready, 0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_op_valid", op_valid, 0);
    check("t6_clear_req", clear_req, 0);
    check("t6_print_req", print_req, 0);
    check("t6_ready", cmd_ready, 1);
`ifdef DISPATCH_STATS_EN
    check("t6_stat_reads", stat_reads, 0);
    check("t6_stat_writes", stat_writes, 0);
    check("t6_stat_snoops", stat_snoops, 0);
`endif
    cyc();
    cyc();
    check("t6_no_clear_after_reset", n_clear - cnt0, 0);
    check("end_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
